// File: rtl/gtech_piso8_tx.sv
// gtech_piso8_tx: parallel-in/serial-out transmitter with valid/ready load,
// stall-able shifting, and frame valid/last markers.
module gtech_piso8_tx #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             CP,
   input  logic             CD,
   input  logic [WIDTH-1:0] D,
   input  logic             LD_VALID,
   output logic             LD_READY,
   input  logic             SO_EN,
   output logic             SO,
   output logic             SO_VALID,
   output logic             SO_LAST,
   output logic             BUSY
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             active, last, load;

   assign active   = state_q == SHIFT;
   assign last     = active && cnt_q == CW'(WIDTH - 1);
   // Ready is gated by CD so nothing can be accepted while reset is held.
   assign LD_READY = CD && (!active || (last && SO_EN));
   assign load     = LD_VALID && LD_READY;
   assign SO       = active ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_LEVEL;
   assign SO_VALID = active;
   assign SO_LAST  = last;
   assign BUSY     = active;

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      if (load) begin
         state_d = SHIFT;
         sh_d    = D;
         cnt_d   = '0;
      end else if (active && SO_EN) begin
         if (last) state_d = IDLE;
         else begin
            sh_d  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_gtech_piso8_tx.sv
// tb_gtech_piso8_tx: table-driven frames plus hand sequences for stall,
// back-to-back, ignored loads and async reset, with a serial scoreboard.
module tb_gtech_piso8_tx;
   logic       CP = 1'b0, CD = 1'b0;
   logic [7:0] d_m = '0, d_l = '0;
   logic       v_m = 1'b0, v_l = 1'b0, en_m = 1'b1, en_l = 1'b1;
   logic       m_rdy, m_so, m_sov, m_last, m_busy;
   logic       l_rdy, l_so, l_sov, l_last, l_busy;
   int         errs = 0, checks = 0;
   logic [1:0] sbq [2][$];

   typedef struct {
      logic [7:0] d;
      bit         msb;
      logic [7:0] seq;
   } vec_t;

   always #5 CP = ~CP;

   gtech_piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_m (
      .CP(CP), .CD(CD), .D(d_m), .LD_VALID(v_m), .LD_READY(m_rdy), .SO_EN(en_m),
      .SO(m_so), .SO_VALID(m_sov), .SO_LAST(m_last), .BUSY(m_busy));

   gtech_piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_l (
      .CP(CP), .CD(CD), .D(d_l), .LD_VALID(v_l), .LD_READY(l_rdy), .SO_EN(en_l),
      .SO(l_so), .SO_VALID(l_sov), .SO_LAST(l_last), .BUSY(l_busy));

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Pop one expected bit per consumed serial bit; push a whole frame per accepted load.
   task automatic mon(int k, logic sov, logic so, logic last, logic en, logic ldv, logic rdy, logic [7:0] d);
      logic [1:0] e;
      if (CD && sov && en) begin
         if (sbq[k].size() == 0) chk($sformatf("sb%0d_underflow", k), 8'd1, 8'd0);
         else begin
            e = sbq[k].pop_front();
            chk($sformatf("sb%0d_so", k), so, e[1]);
            chk($sformatf("sb%0d_last", k), last, e[0]);
         end
      end
      if (CD && ldv && rdy)
         for (int i = 0; i < 8; i++) sbq[k].push_back({k == 0 ? d[7-i] : d[i], i == 7});
   endtask

   task automatic sample();
      @(negedge CP);
      mon(0, m_sov, m_so, m_last, en_m, v_m, m_rdy, d_m);
      mon(1, l_sov, l_so, l_last, en_l, v_l, l_rdy, d_l);
   endtask

   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   initial begin
      vec_t       tbl[5];
      logic [7:0] c3;
      int         total, enabled;
      tbl[0] = '{8'hA5, 1'b1, 8'b10100101};
      tbl[1] = '{8'h01, 1'b0, 8'b10000000};
      tbl[2] = '{8'h80, 1'b0, 8'b00000001};
      tbl[3] = '{8'h3C, 1'b1, 8'b00111100};
      tbl[4] = '{8'h96, 1'b0, 8'b01101001};
      c3 = 8'hC3;
      #1;
      chk("rst_rdy", m_rdy, 0);
      chk("rst_so", m_so, 0);
      chk("rst_sov", m_sov, 0);
      chk("rst_last", m_last, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_l_rdy", l_rdy, 0);
      tick();
      tick();
      CD = 1'b1;
      #1;
      chk("rel_rdy", m_rdy, 1);
      chk("rel_l_rdy", l_rdy, 1);
      chk("rel_sov", m_sov, 0);
      for (int k = 0; k < 5; k++) begin
         if (tbl[k].msb) begin d_m = tbl[k].d; v_m = 1'b1; end
         else begin d_l = tbl[k].d; v_l = 1'b1; end
         sample();
         chk("tbl_ldrdy", tbl[k].msb ? m_rdy : l_rdy, 1);
         tick();
         v_m = 1'b0;
         v_l = 1'b0;
         d_m = ~tbl[k].d;
         d_l = ~tbl[k].d;
         for (int i = 0; i < 8; i++) begin
            sample();
            chk($sformatf("tbl%0d_so%0d", k, i), tbl[k].msb ? m_so : l_so, tbl[k].seq[7-i]);
            chk($sformatf("tbl%0d_last%0d", k, i), tbl[k].msb ? m_last : l_last, i == 7);
            chk($sformatf("tbl%0d_sov%0d", k, i), tbl[k].msb ? m_sov : l_sov, 1);
            tick();
         end
         sample();
         chk($sformatf("tbl%0d_end_sov", k), tbl[k].msb ? m_sov : l_sov, 0);
         chk($sformatf("tbl%0d_end_so", k), tbl[k].msb ? m_so : l_so, 0);
         tick();
      end
      d_m = 8'hF0;
      v_m = 1'b1;
      sample();
      tick();
      v_m = 1'b0;
      total = 0;
      enabled = 0;
      for (int n = 1; n <= 20; n++) begin
         en_m = !(n >= 2 && n <= 4);
         sample();
         if (!m_sov) break;
         total++;
         if (en_m) enabled++;
         else chk("stall_hold_so", m_so, 1);
         chk("stall_last", m_last, n == 11);
         tick();
      end
      en_m = 1'b1;
      chk("stall_total", total, 11);
      chk("stall_enabled", enabled, 8);
      tick();
      d_m = 8'hFF;
      v_m = 1'b1;
      sample();
      tick();
      d_m = 8'h00;
      for (int n = 1; n <= 16; n++) begin
         sample();
         chk("b2b_sov", m_sov, 1);
         chk("b2b_so", m_so, n <= 8);
         chk("b2b_rdy", m_rdy, n == 8 || n == 16);
         tick();
         if (n == 8) v_m = 1'b0;
      end
      sample();
      chk("b2b_end_sov", m_sov, 0);
      tick();
      d_m = c3;
      v_m = 1'b1;
      sample();
      tick();
      for (int n = 1; n <= 9; n++) begin
         v_m = n == 4;
         if (n == 4) d_m = 8'h3C;
         sample();
         if (n == 4) chk("ign_rdy", m_rdy, 0);
         chk("ign_so", m_so, n <= 8 ? c3[8-n] : 1'b0);
         chk("ign_sov", m_sov, n <= 8);
         tick();
      end
      d_m = 8'h5A;
      v_m = 1'b1;
      sample();
      tick();
      v_m = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         sample();
         tick();
      end
      en_m = 1'b0;
      v_m = 1'b1;
      d_m = 8'hFF;
      sample();
      chk("lstall_rdy", m_rdy, 0);
      chk("lstall_last", m_last, 1);
      tick();
      sample();
      chk("lstall_hold_last", m_last, 1);
      chk("lstall_hold_so", m_so, 0);
      tick();
      v_m = 1'b0;
      en_m = 1'b1;
      sample();
      chk("lstall_rel_rdy", m_rdy, 1);
      tick();
      sample();
      chk("lstall_end_sov", m_sov, 0);
      tick();
      d_m = 8'hA5;
      d_l = 8'hA5;
      v_m = 1'b1;
      v_l = 1'b1;
      sample();
      tick();
      v_m = 1'b0;
      v_l = 1'b0;
      sample();
      tick();
      sample();
      tick();
      #2;
      CD = 1'b0;
      #1;
      chk("arst_so", m_so, 0);
      chk("arst_sov", m_sov, 0);
      chk("arst_busy", m_busy, 0);
      chk("arst_rdy", m_rdy, 0);
      chk("arst_last", m_last, 0);
      chk("arst_l_sov", l_sov, 0);
      chk("arst_l_rdy", l_rdy, 0);
      sbq[0].delete();
      sbq[1].delete();
      tick();
      tick();
      CD = 1'b1;
      #1;
      chk("arel_rdy", m_rdy, 1);
      chk("arel_sov", m_sov, 0);
      sample();
      chk("arel_noreplay", m_sov, 0);
      chk("arel_l_noreplay", l_sov, 0);
      tick();
      chk("sb0_empty", 8'(sbq[0].size()), 0);
      chk("sb1_empty", 8'(sbq[1].size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/gtech_piso8_tx.md
Name: gtech_piso8_tx

Overview:
- Parallel-in/serial-out transmitter: the read-out end of our 8-bit parallel flop banks.
- Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per enabled CP cycle, with frame and last-bit markers.
- Drives serial links and scan-style readback chains from register banks into a matching serial-in capture block.

Parameters:
- WIDTH, 8, data word width; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first.
- IDLE_LEVEL, 1'b0, value driven on SO when no frame is active.

Ports:
- CP  input  1  clock; all state updates on the rising edge.
- CD  input  1  reset; asynchronous, active-low; clears all state immediately.
- D  input  WIDTH  parallel word to transmit.
- LD_VALID  input  1  D is valid and requests a load.
- LD_READY  output  1  block accepts D this cycle.
- SO_EN  input  1  shift enable from the downstream sink; 0 = stall.
- SO  output  1  serial data out.
- SO_VALID  output  1  SO carries a frame bit.
- SO_LAST  output  1  current SO is the final bit of the frame.
- BUSY  output  1  a frame is in progress.

Behaviour:
- Reset (CD low, asynchronous):
  - state = IDLE, shift register = 0, bit counter = 0.
  - SO = IDLE_LEVEL, SO_VALID = 0, SO_LAST = 0, BUSY = 0.
  - LD_READY is forced to 0 while CD is low; it rises combinationally once CD deasserts.
- States:
  - IDLE: no frame. SO = IDLE_LEVEL, SO_VALID = 0, LD_READY = 1.
    - Load fires on a CP edge when LD_VALID & LD_READY: D is captured into the shift register, counter = 0, state -> SHIFT.
  - SHIFT: SO_VALID = 1, BUSY = 1.
    - SO is the current head bit: shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
    - SO_LAST = (counter == WIDTH-1).
- Latency: the first bit appears on SO in the cycle after the load edge.
- Shifting:
  - On a CP edge with SO_EN = 1 and not last: shift toward the head, fill with 0, counter += 1.
  - With SO_EN = 0: shift register, counter, and SO all hold; stall length is unbounded.
  - On a CP edge with SO_EN = 1 and last: the frame ends.
    - If LD_VALID = 1, a back-to-back load occurs: D is captured, counter = 0, state stays SHIFT, with no idle gap.
    - Otherwise state -> IDLE.
- LD_READY = (state == IDLE) | (state == SHIFT & SO_LAST & SO_EN); combinational.
- While LD_READY = 0, LD_VALID and D are ignored; D need not be held after the load edge.
- Frame length: exactly WIDTH enabled cycles per accepted word.
- Counter width: clog2(WIDTH). It never exceeds WIDTH-1, and it wraps to 0 only on a load.
- Reset mid-frame: the frame is abandoned immediately (asynchronously). No partial bits are replayed after CD releases.
- LD_VALID with SO_EN = 0 during the last bit: no load occurs; the last bit holds.

Test Plan:
- Reset checks:
  - Assert CD = 0 mid-operation -> SO = IDLE_LEVEL, SO_VALID = 0, BUSY = 0, and LD_READY = 0 immediately, without waiting for a CP edge.
  - Release CD -> LD_READY = 1.
- MSB_FIRST = 1, SO_EN = 1:
  - Load D = 8'hA5 -> SO sequence 1,0,1,0,0,1,0,1 on cycles 1..8 after the load.
  - SO_LAST high only on cycle 8; SO_VALID low on cycle 9.
- MSB_FIRST = 0:
  - Load D = 8'h01 -> SO = 1 on cycle 1, then 0 for 7 cycles.
  - Load D = 8'h80 -> SO = 1 only on cycle 8.
- Stall check:
  - Load 8'hF0, then drop SO_EN for 3 cycles after bit 2 -> SO holds 1 and the counter holds.
  - Frame completes after 11 total cycles, 8 enabled.
- Back-to-back:
  - Hold LD_VALID = 1 with 8'hFF then 8'h00 -> LD_READY pulses during the last bit.
  - SO shows 8 ones then 8 zeros with no gap; SO_VALID stays 1 for 16 cycles.
- Ignored loads:
  - LD_VALID pulses mid-frame (counter = 3) with D = 8'h3C -> ignored; the current frame is unaltered.
